result_serializer: RTL and testbench

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/result_serializer.sv | 98 +++++++++
 tb/tb_result_serializer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// Parallel-to-serial converter for a captured compressor result word.
// Valid/ready on both sides; a new word may be loaded on the cycle its predecessor's last bit leaves.
module result_serializer #(
    parameter int unsigned WIDTH     = 61,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_last,
    output logic             busy
);

    localparam int unsigned     CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_shift, w_shift_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic             w_load, w_adv, w_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_load) w_state_next = StShift;
            end
            StShift: begin
                if (w_load)               w_state_next = StShift;
                else if (w_adv && w_last) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Output and handshake logic
    always_comb begin
        w_last     = (r_state == StShift) && (r_cnt == LAST_IDX);
        load_ready = (r_state == StIdle) || (w_last && sout_ready);
        w_load     = load_valid && load_ready;
        w_adv      = (r_state == StShift) && sout_ready;
        sout_valid = (r_state == StShift);
        busy       = (r_state == StShift);
        sout_last  = w_last;
        if (r_state == StShift) begin
            sout = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
        end else begin
            sout = 1'b0;
        end
    end

    // Datapath: the outgoing bit always sits at the output end of the shift register
    always_comb begin
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        if (w_load) begin
            w_shift_next = din;
            w_cnt_next   = '0;
        end else if (w_adv) begin
            if (w_last) begin
                w_shift_next = '0;
                w_cnt_next   = '0;
            end else begin
                w_shift_next = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                         : {1'b0, r_shift[WIDTH-1:1]};
                w_cnt_next   = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: LSB-first instance for most scenarios,
// a second MSB-first instance for bit-order checking.
module tb_result_serializer;

    localparam int W = 61;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         load_valid, load_ready, sout, sout_valid, sout_ready, sout_last, busy;
    logic [W-1:0] m_din;
    logic         m_load_valid, m_load_ready, m_sout, m_sout_valid, m_sout_ready;
    logic         m_sout_last, m_busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    result_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_ready (sout_ready),
        .sout_last  (sout_last),
        .busy       (busy)
    );

    result_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (m_din),
        .load_valid (m_load_valid),
        .load_ready (m_load_ready),
        .sout       (m_sout),
        .sout_valid (m_sout_valid),
        .sout_ready (m_sout_ready),
        .sout_last  (m_sout_last),
        .busy       (m_busy)
    );

    // Receives one word from the LSB-first instance; called at posedge+1 of the cycle
    // that should present bit 0. Returns at posedge+1 after the last accepted bit.
    task automatic collect(input int stall_pct, input int budget, output logic [W-1:0] word,
                           output int nbits, output int last_at, output int stall_err);
        bit   done, prev_stall;
        logic held_b, held_l;
        word = '0; nbits = 0; last_at = -1; stall_err = 0;
        done = 1'b0; prev_stall = 1'b0; held_b = 1'b0; held_l = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            sout_ready = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
            @(negedge clk);
            if (prev_stall && (sout_valid !== 1'b1 || sout !== held_b || sout_last !== held_l))
                stall_err++;
            if (sout_valid !== 1'b1) begin
                done = 1'b1;
            end else if (sout_ready) begin
                if (nbits < W) word[nbits] = sout;
                if (sout_last === 1'b1) begin
                    last_at = nbits;
                    done    = 1'b1;
                end
                nbits++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                held_b     = sout;
                held_l     = sout_last;
            end
            @(posedge clk); #1;
        end
        sout_ready = 1'b1;
    endtask

    task automatic load_word(input logic [W-1:0] value);
        din = value; load_valid = 1'b1; sout_ready = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_total++;
        if (sout !== 1'b0 || sout_valid !== 1'b0 || sout_last !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_outputs: got sout=%b valid=%b last=%b busy=%b, want all 0",
                     sout, sout_valid, sout_last, busy);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++;
        if (load_ready !== 1'b1) $display("FAIL reset_load_ready: got %b want 1", load_ready);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [W-1:0] word;
        int nbits, last_at, serr;
        din = 61'h1; load_valid = 1'b1; sout_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (load_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", load_ready);
        else n_pass++;
        @(posedge clk); #1;
        load_valid = 1'b0;
        collect(0, 100, word, nbits, last_at, serr);
        n_total++;
        if (word !== 61'h1) $display("FAIL single_word: got %h want %h", word, 61'h1);
        else n_pass++;
        n_total++;
        if (nbits !== 61) $display("FAIL single_count: got %0d want 61", nbits);
        else n_pass++;
        n_total++;
        if (last_at !== 60) $display("FAIL single_last_pos: got %0d want 60", last_at);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (sout_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1)
            $display("FAIL single_idle_after: got valid=%b busy=%b ready=%b want 0 0 1",
                     sout_valid, busy, load_ready);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random_stall();
        logic [W-1:0] word;
        int nbits, last_at, serr;
        load_word(61'h1555_5555_5555_5555);
        collect(50, 2000, word, nbits, last_at, serr);
        n_total++;
        if (word !== 61'h1555_5555_5555_5555)
            $display("FAIL stall_word: got %h want %h", word, 61'h1555_5555_5555_5555);
        else n_pass++;
        n_total++;
        if (nbits !== 61 || last_at !== 60)
            $display("FAIL stall_count: got %0d bits last@%0d want 61 last@60", nbits, last_at);
        else n_pass++;
        n_total++;
        if (serr !== 0) $display("FAIL stall_hold: got %0d unstable stalls want 0", serr);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, wa, wb;
        int nvalid, nlast;
        a = 61'h0ABC_DEF0_1234_5678;
        b = 61'h1F0F_0F0F_0F0F_0F0F;
        wa = '0; wb = '0; nvalid = 0; nlast = 0;
        load_word(a);
        for (int c = 0; c < 122; c++) begin
            if (c == 60) begin
                din = b; load_valid = 1'b1;
            end else begin
                load_valid = 1'b0;
            end
            @(negedge clk);
            if (sout_valid === 1'b1) nvalid++;
            if (sout_last === 1'b1) nlast++;
            if (c < 61) wa[c] = sout;
            else wb[c-61] = sout;
            if (c == 60) begin
                n_total++;
                if (load_ready !== 1'b1) $display("FAIL b2b_reload_ready: got %b want 1", load_ready);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        n_total++;
        if (nvalid !== 122) $display("FAIL b2b_valid_cycles: got %0d want 122", nvalid);
        else n_pass++;
        n_total++;
        if (nlast !== 2) $display("FAIL b2b_last_count: got %0d want 2", nlast);
        else n_pass++;
        n_total++;
        if (wa !== a) $display("FAIL b2b_word_a: got %h want %h", wa, a);
        else n_pass++;
        n_total++;
        if (wb !== b) $display("FAIL b2b_word_b: got %h want %h", wb, b);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (sout_valid !== 1'b0) $display("FAIL b2b_idle_after: got %b want 0", sout_valid);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_msb_first();
        logic [W-1:0] v;
        logic first;
        int ones, nvalid, last_at;
        v = '0; v[W-1] = 1'b1;
        first = 1'b0; ones = 0; nvalid = 0; last_at = -1;
        m_din = v; m_load_valid = 1'b1; m_sout_ready = 1'b1;
        @(posedge clk); #1;
        m_load_valid = 1'b0;
        for (int c = 0; c < 61; c++) begin
            @(negedge clk);
            if (c == 0) first = m_sout;
            if (m_sout_valid === 1'b1) nvalid++;
            if (m_sout === 1'b1) ones++;
            if (m_sout_last === 1'b1) last_at = c;
            @(posedge clk); #1;
        end
        n_total++;
        if (first !== 1'b1) $display("FAIL msb_first_bit: got %b want 1", first);
        else n_pass++;
        n_total++;
        if (ones !== 1) $display("FAIL msb_ones: got %0d want 1", ones);
        else n_pass++;
        n_total++;
        if (nvalid !== 61 || last_at !== 60)
            $display("FAIL msb_count: got %0d valid last@%0d want 61 last@60", nvalid, last_at);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] word;
        int nbits, last_at, serr, resid;
        resid = 0;
        load_word('1);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (sout !== 1'b0 || sout_valid !== 1'b0 || sout_last !== 1'b0 || busy !== 1'b0)
            $display("FAIL async_reset: got sout=%b valid=%b last=%b busy=%b want all 0",
                     sout, sout_valid, sout_last, busy);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (sout_valid !== 1'b0 || sout !== 1'b0) resid++;
        end
        n_total++;
        if (resid !== 0) $display("FAIL reset_residual: got %0d residual cycles want 0", resid);
        else n_pass++;
        n_total++;
        if (load_ready !== 1'b1) $display("FAIL reset_mid_ready: got %b want 1", load_ready);
        else n_pass++;
        // Load held across release: the first rising edge must capture it
        rst_n = 1'b0;
        din = 61'h0F0F_1234_ABCD_0F0F; load_valid = 1'b1; sout_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        collect(0, 100, word, nbits, last_at, serr);
        n_total++;
        if (word !== 61'h0F0F_1234_ABCD_0F0F || nbits !== 61)
            $display("FAIL reset_reload: got %h (%0d bits) want %h (61 bits)",
                     word, nbits, 61'h0F0F_1234_ABCD_0F0F);
        else n_pass++;
    endtask

    task automatic test_ignore_load();
        logic [W-1:0] x, wx;
        x = 61'h0123_4567_89AB_CDEF;
        wx = '0;
        load_word(x);
        for (int c = 0; c < 61; c++) begin
            load_valid = (c < 59);
            din = W'({$urandom(), $urandom()});
            @(negedge clk);
            wx[c] = sout;
            if (c == 10) begin
                n_total++;
                if (load_ready !== 1'b0) $display("FAIL ignore_ready: got %b want 0", load_ready);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
        n_total++;
        if (wx !== x) $display("FAIL ignore_word: got %h want %h", wx, x);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (sout_valid !== 1'b0) $display("FAIL ignore_no_capture: got %b want 0", sout_valid);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        din = '0; load_valid = 1'b0; sout_ready = 1'b0;
        m_din = '0; m_load_valid = 1'b0; m_sout_ready = 1'b0;
        test_reset();
        test_single();
        test_random_stall();
        test_back_to_back();
        test_msb_first();
        test_ignore_load();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
